// File: rtl/vc_rr_arbiter.sv
// Round-robin arbiter that drains input virtual-channel FIFOs into destination FIFOs.
//
// One non-empty input FIFO is granted at a time and may pop up to BURST words before
// the grant is released. Each popped word is forwarded to the destination FIFO named
// by its top DEST_WIDTH bits. Popping stalls while that destination is almost full.
//
// Ports:
//   clk              clock, rising edge
//   reset_L          asynchronous active-low reset
//   enable           permission to start new grants (ignored mid-burst)
//   fifo_empty       empty flag per input FIFO
//   fifo_data        head word per input FIFO, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dest_almost_full almost-full flag per destination FIFO
//   pop              combinational pop strobe to the input FIFOs (at most one bit)
//   push             registered push strobe to the destination FIFOs (at most one bit)
//   data_out         registered word accompanying push
//   grant            registered one-hot current grant, zero when idle
//   busy             registered, high while a grant is held
module vc_rr_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_WIDTH = 2,
    parameter int NUM_REQ    = 4,
    parameter int BURST      = 4
) (
    input  logic                            clk,
    input  logic                            reset_L,
    input  logic                            enable,
    input  logic [NUM_REQ-1:0]              fifo_empty,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   fifo_data,
    input  logic [(2**DEST_WIDTH)-1:0]      dest_almost_full,
    output logic [NUM_REQ-1:0]              pop,
    output logic [(2**DEST_WIDTH)-1:0]      push,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy
);

    localparam int NUM_DEST = 2**DEST_WIDTH;
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W    = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [NUM_DEST-1:0]   push_q, push_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic                  busy_q, busy_d;

    logic [DATA_WIDTH-1:0] head;
    logic [DEST_WIDTH-1:0] dest;
    logic                  gnt_empty;
    logic                  pop_fire;
    logic                  found;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      cand;

    // Head word of the granted requester.
    always_comb begin
        head = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx_q == IDX_W'(i)) begin
                head = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign dest      = head[DATA_WIDTH-1 -: DEST_WIDTH];
    assign gnt_empty = fifo_empty[gnt_idx_q];
    assign pop_fire  = (state_q == GRANT) && !gnt_empty && !dest_almost_full[dest];

    // Search starts just after the last served requester, so it is considered last.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && !fifo_empty[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        push_d      = '0;
        data_out_d  = data_out_q;
        pop         = '0;

        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    state_d          = GRANT;
                    gnt_idx_d        = sel_idx;
                    burst_cnt_d      = '0;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    busy_d           = 1'b1;
                end
            end
            GRANT: begin
                pop[gnt_idx_q] = pop_fire;
                if (gnt_empty) begin
                    state_d  = IDLE;
                    rr_ptr_d = gnt_idx_q;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                end else if (pop_fire) begin
                    push_d[dest] = 1'b1;
                    data_out_d   = head;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = gnt_idx_q;
                        grant_d  = '0;
                        busy_d   = 1'b0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end
                // Otherwise stalled on almost-full: hold grant and count.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            push_q      <= '0;
            data_out_q  <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            push_q      <= push_d;
            data_out_q  <= data_out_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    assign push     = push_q;
    assign data_out = data_out_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

endmodule
